// File: rtl/instr_sequencer.sv
// instr_sequencer: small program store that replays a loaded instruction
// list to the core. Each entry is held for HOLD_CYCLES clocks, and NOP is
// driven whenever no program entry is being issued.
// Optional feature: define SEQ_LOOP_EN so that the loop input restarts the
// program at entry 0 instead of finishing it.
module instr_sequencer #(
    parameter int INSTRUCTION_WIDTH = 15,
    parameter int DEPTH             = 16,
    parameter int HOLD_CYCLES       = 2,
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP = 15'b1_0000_1011_00_00_00,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_en,
    input  logic [AW-1:0]                load_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] load_data,
    input  logic [AW:0]                  prog_len,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [AW-1:0]                pc,
    output logic                         busy,
    output logic                         done
);
    localparam int LW = AW + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                       state_q, state_d;
    logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
    logic [AW-1:0]                pc_q, pc_d;
    logic [HW-1:0]                hold_q, hold_d;
    logic [LW-1:0]                len_q, len_d;
    logic                         done_q, done_d;
    logic                         last_entry, hold_end;
    logic [AW-1:0]                pc_inc;

    logic [INSTRUCTION_WIDTH-1:0] mem [DEPTH];

`ifndef SEQ_LOOP_EN
    // loop has no effect unless the loop feature is built in.
    logic unused_loop;
    assign unused_loop = loop;
`endif

    assign instruction = instr_q;
    assign pc          = pc_q;
    assign busy        = (state_q == RUN);
    assign done        = done_q;

    // Program store: writable only while idle; reset leaves contents intact.
    always_ff @(posedge clk) begin
        if (!rst && load_en && state_q == IDLE)
            mem[load_addr] <= load_data;
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            instr_q <= NOP;
            pc_q    <= '0;
            hold_q  <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    // Next-state: start/stop handling, hold counting, pc advance and completion.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        len_d      = len_q;
        done_d     = 1'b0;
        pc_inc     = pc_q + AW'(1);  // wraps modulo DEPTH
        last_entry = ({1'b0, pc_q} == (len_q - LW'(1)));
        hold_end   = (hold_q == HW'(HOLD_CYCLES - 1));
        case (state_q)
            IDLE: begin
                instr_d = NOP;
                pc_d    = '0;
                hold_d  = '0;
                // stop beats start; an empty program is not started
                if (start && !stop && prog_len != '0) begin
                    state_d = RUN;
                    instr_d = mem[AW'(0)];
                    len_d   = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    instr_d = NOP;
                    pc_d    = '0;
                    hold_d  = '0;
                end else if (!hold_end) begin
                    hold_d = hold_q + HW'(1);
                end else begin
                    hold_d = '0;
                    if (last_entry) begin
                        done_d = 1'b1;
`ifdef SEQ_LOOP_EN
                        if (loop) begin
                            pc_d    = '0;
                            instr_d = mem[AW'(0)];
                        end else
`endif
                        begin
                            state_d = IDLE;
                            instr_d = NOP;
                            pc_d    = '0;
                        end
                    end else begin
                        pc_d    = pc_inc;
                        instr_d = mem[pc_inc];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                instr_d = NOP;
                pc_d    = '0;
                hold_d  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer (default build, loop feature disabled):
// a table of per-cycle vectors plus a hand-written run for the length clamp.
module tb_instr_sequencer;
    localparam int W = 15;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam logic [W-1:0] NOPV = 15'h42C0;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [W-1:0]  load_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop = 1'b0;
    logic [W-1:0]  instruction;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;

    int total = 0;
    int bad = 0;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .start(start),
        .stop(stop), .loop(loop), .instruction(instruction), .pc(pc),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst, start, stop, load_en;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic [AW:0]   len;
        logic [W-1:0]  e_instr;
        logic [AW-1:0] e_pc;
        logic          e_busy, e_done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic s, logic p, logic l,
                                logic [AW-1:0] a, logic [W-1:0] d, logic [AW:0] n,
                                logic [W-1:0] ei, logic [AW-1:0] ep, logic eb, logic ed);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.load_en = l;
        v.addr = a; v.data = d; v.len = n;
        v.e_instr = ei; v.e_pc = ep; v.e_busy = eb; v.e_done = ed;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(string tag, int idx, logic [W-1:0] ei, logic [AW-1:0] ep,
                             logic eb, logic ed);
        chk({tag, ".instr"}, idx, 32'(instruction), 32'(ei));
        chk({tag, ".pc"},    idx, 32'(pc),          32'(ep));
        chk({tag, ".busy"},  idx, 32'(busy),        32'(eb));
        chk({tag, ".done"},  idx, 32'(done),        32'(ed));
    endtask

    initial begin
        // rst start stop load addr data len | instr pc busy done
        tbl.push_back(mk(1,0,0,0, 0, 0,      0, NOPV,    0, 0, 0)); // reset
        tbl.push_back(mk(0,0,0,1, 0, 'h0A0E, 0, NOPV,    0, 0, 0)); // load
        tbl.push_back(mk(0,0,0,1, 1, 'h0300, 0, NOPV,    0, 0, 0));
        tbl.push_back(mk(0,0,0,1, 2, 'h0B1A, 0, NOPV,    0, 0, 0));
        tbl.push_back(mk(0,1,0,0, 0, 0,      3, 'h0A0E,  0, 1, 0)); // normal run
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, 'h0A0E,  0, 1, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, 'h0300,  1, 1, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, 'h0300,  1, 1, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, 'h0B1A,  2, 1, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, 'h0B1A,  2, 1, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, NOPV,    0, 0, 1)); // done pulse
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, NOPV,    0, 0, 0));
        tbl.push_back(mk(0,1,0,0, 0, 0,      3, 'h0A0E,  0, 1, 0)); // load during run
        tbl.push_back(mk(0,0,0,1, 0, 'h7FFF, 0, 'h0A0E,  0, 1, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, 'h0300,  1, 1, 0));
        tbl.push_back(mk(0,0,1,0, 0, 0,      0, NOPV,    0, 0, 0)); // stop in entry 1
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, NOPV,    0, 0, 0));
        tbl.push_back(mk(0,1,0,0, 0, 0,      3, 'h0A0E,  0, 1, 0)); // entry 0 intact
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, 'h0A0E,  0, 1, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, 'h0300,  1, 1, 0));
        tbl.push_back(mk(1,0,0,0, 0, 0,      0, NOPV,    0, 0, 0)); // rst mid-run
        tbl.push_back(mk(0,1,1,0, 0, 0,      3, NOPV,    0, 0, 0)); // stop beats start
        tbl.push_back(mk(0,1,0,0, 0, 0,      0, NOPV,    0, 0, 0)); // len 0 ignored
        tbl.push_back(mk(0,1,0,0, 0, 0,      3, 'h0A0E,  0, 1, 0)); // replay
        tbl.push_back(mk(0,1,0,0, 0, 0,      1, 'h0A0E,  0, 1, 0)); // start in RUN ignored
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, 'h0300,  1, 1, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, 'h0300,  1, 1, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, 'h0B1A,  2, 1, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, 'h0B1A,  2, 1, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, NOPV,    0, 0, 1));
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, NOPV,    0, 0, 0));
        tbl.push_back(mk(1,0,0,1, 0, 'h1234, 0, NOPV,    0, 0, 0)); // rst beats load
        tbl.push_back(mk(0,1,0,0, 0, 0,      1, 'h0A0E,  0, 1, 0)); // 1-entry run
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, 'h0A0E,  0, 1, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0,      0, NOPV,    0, 0, 1));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; start = tbl[i].start; stop = tbl[i].stop;
            load_en = tbl[i].load_en; load_addr = tbl[i].addr;
            load_data = tbl[i].data; prog_len = tbl[i].len;
            @(posedge clk); #1;
            check_all("vec", i, tbl[i].e_instr, tbl[i].e_pc, tbl[i].e_busy, tbl[i].e_done);
        end
        rst = 0; start = 0; stop = 0; load_en = 0;

        // Clamp: fill every entry, start with DEPTH+1 and loop=1 (ignored here).
        for (int i = 0; i < DEPTH; i++) begin
            load_en = 1; load_addr = AW'(i); load_data = W'(16'h0100 + i);
            @(posedge clk); #1;
        end
        load_en = 0;
        loop = 1; start = 1; prog_len = 5'(DEPTH + 1);
        @(posedge clk); #1;
        start = 0; prog_len = 0;
        for (int k = 0; k < 2 * DEPTH; k++) begin
            check_all("clamp", k, W'(16'h0100 + k / 2), AW'(k / 2), 1'b1, 1'b0);
            @(posedge clk); #1;
        end
        check_all("clamp_end", 0, NOPV, 0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_all("clamp_idle", 0, NOPV, 0, 1'b0, 1'b0);
        loop = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter INSTRUCTION_WIDTH, default 15: width of each issued instruction word.
REQ-002 Parameter DEPTH, default 16: program store entries, power of two, >=2; AW = log2(DEPTH).
REQ-003 Parameter HOLD_CYCLES, default 2: clocks each instruction is held on the output, >=1.
REQ-004 Parameter NOP, default 15'b1_0000_1011_00_00_00: word driven whenever no program instruction is issued.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 load_en  input  1  write load_data into the store at load_addr.
REQ-008 load_addr  input  AW  store write address.
REQ-009 load_data  input  INSTRUCTION_WIDTH  store write data.
REQ-010 prog_len  input  AW+1  program length, sampled on an accepted start.
REQ-011 start  input  1  begin execution from entry 0.
REQ-012 stop  input  1  abort execution.
REQ-013 loop  input  1  restart at entry 0 after the last entry (see Configuration).
REQ-014 instruction  output  INSTRUCTION_WIDTH  registered instruction to the core.
REQ-015 pc  output  AW  index of the entry currently on instruction.
REQ-016 busy  output  1  high in state RUN.
REQ-017 done  output  1  one-cycle pulse on normal program completion.

Function
REQ-018 The FSM SHALL have exactly the states IDLE and RUN.
REQ-019 In IDLE, a load_en write SHALL take effect on the next edge; in RUN, load_en SHALL be ignored.
REQ-020 In IDLE, start=1 with prog_len>0 SHALL enter RUN on the next edge, with instruction=store[0], pc=0 and hold count 0.
REQ-021 start with prog_len=0 SHALL be ignored; start while in RUN SHALL be ignored.
REQ-022 A prog_len value above DEPTH SHALL be clamped to DEPTH when latched.
REQ-023 In RUN, the hold count SHALL increment each cycle; at HOLD_CYCLES-1 it SHALL reset to 0 and pc SHALL advance, so every entry is on instruction for exactly HOLD_CYCLES cycles.
REQ-024 When the last entry (pc = latched length - 1) finishes its hold, the block SHALL return to IDLE with instruction=NOP, pc=0, and done=1 for that single cycle.
REQ-025 Outside RUN, instruction SHALL equal NOP.
REQ-026 stop=1 in RUN SHALL return the block to IDLE on the next edge with instruction=NOP and pc=0, without asserting done.
REQ-027 If start and stop are both high in the same cycle, stop SHALL win.
REQ-028 pc and the store address SHALL wrap modulo DEPTH; no out-of-range read SHALL occur.

Reset
REQ-029 rst=1 SHALL force IDLE, instruction=NOP, pc=0, busy=0, done=0, hold count=0 and latched length=0 on the next edge, including mid-RUN.
REQ-030 Store contents SHALL NOT be cleared by rst.
REQ-031 rst SHALL take priority over start, stop and load_en.

Configuration
REQ-032 With macro SEQ_LOOP_EN defined and loop=1 at the last entry's final hold cycle, pc SHALL wrap to 0, RUN SHALL continue, and done SHALL pulse once per wrap.
REQ-033 Without SEQ_LOOP_EN, the loop input SHALL be ignored and REQ-024 SHALL always apply.

Verification
REQ-034 Load the store with [0x0A0E, 0x0300, 0x0B1A], then start with prog_len=3 and HOLD_CYCLES=2 -> instruction sequence 0x0A0E,0x0A0E,0x0300,0x0300,0x0B1A,0x0B1A, then NOP; done high for 1 cycle; busy high for 6 cycles.
REQ-035 Assert stop during the second entry -> next cycle state IDLE, instruction=NOP, pc=0, done never asserted.
REQ-036 Assert rst in cycle 3 of RUN -> next cycle instruction=NOP, busy=0; a later start replays the unchanged store from entry 0.
REQ-037 Drive start with prog_len=0, then start with prog_len=DEPTH+1 -> first ignored (busy stays 0); second runs exactly DEPTH entries.
REQ-038 Build with SEQ_LOOP_EN, set loop=1 and prog_len=2 -> entries 0,1,0,1 repeat; done pulses at each wrap; stop ends the run.
REQ-039 Drive load_en=1 during RUN with load_addr=0 -> the store is unchanged; the next run issues the original entry 0.
